ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 1024x8 behavioural RAM (ram_1024_word_b).
- Shares the RAM's single read port and single write port between requester A (fetch side) and requester B (load/store side).
- Runs a full-memory clear sweep on command.
- Sits between the CPU front-end/LSU and the RAM instance. All RAM control comes from registered state.

Parameters:
- AW, 10, address width (2**AW words swept by clear)
- DW, 8, data width
- FILL, 8'h00, value written to every word during a clear sweep

Ports:
- CLK  in  1  clock; all state changes on posedge
- RST_N  in  1  reset, synchronous, active-low
- A_REQ  in  1  requester A access request; held high until A_ACK
- A_WR  in  1  A: 1 = write, 0 = read; held stable with A_REQ
- A_ADDR  in  AW  A word address
- A_WD  in  DW  A write data
- A_ACK  out  1  one-cycle completion pulse to A
- A_RD  out  DW  A read data; valid in the A_ACK cycle, held until A's next read completes
- B_REQ, B_WR, B_ADDR, B_WD, B_ACK, B_RD  same as the A ports, for requester B
- CLR  in  1  one-cycle pulse: start the clear sweep
- BUSY  out  1  high while the clear sweep runs
- RAM_WE  out  1  to RAM WE
- RAM_RE  out  1  to RAM RE
- RAM_RA  out  AW  to RAM RA
- RAM_WA  out  AW  to RAM WA
- RAM_WD  out  DW  to RAM WD
- RAM_Q  in  DW  from RAM Q; combinational read, high-Z when RE = 0

Behaviour:
- States: IDLE, ACCESS, DONE, CLEAR. All are registered.
- Reset (RST_N sampled low):
  - State goes to IDLE; last-served pointer LAST goes to B, so A wins the first tie.
  - Clear counter goes to 0.
  - A_ACK = B_ACK = BUSY = 0 and A_RD = B_RD = 0.
  - RAM_WE = RAM_RE = 0 and RAM_RA = RAM_WA = RAM_WD = 0.
  - RAM_WE is gated with RST_N, so no write commits on an edge where reset is asserted, including mid-ACCESS or mid-CLEAR.
- IDLE:
  - CLR high takes priority: go to CLEAR and set BUSY. Pending REQs stay pending.
  - Otherwise, with exactly one REQ high: grant it.
  - With both REQs high: grant the requester that is not LAST.
  - On a grant: latch the winner's WR/ADDR/WD into command registers, record the winner and update LAST, then go to ACCESS.
  - With no REQ: stay in IDLE.
- ACCESS (one cycle):
  - Write: RAM_WE = 1, RAM_WA = latched ADDR, RAM_WD = latched WD, RAM_RE = 0. The RAM commits at the closing edge.
  - Read: RAM_RE = 1, RAM_RA = latched ADDR, RAM_WE = 0. RAM_Q is captured into the winner's RD register at the closing edge.
  - Next state is DONE.
- DONE (one cycle):
  - The winner's ACK = 1; the other ACK stays 0. RAM_WE = RAM_RE = 0.
  - No arbitration occurs in DONE. The requester drops REQ on the ACK edge.
  - Next state is IDLE.
  - Latency from REQ sampled in IDLE to ACK is 2 cycles. Throughput is one access per 3 cycles.
- CLEAR:
  - Each cycle: RAM_WE = 1, RAM_WA = counter, RAM_WD = FILL, RAM_RE = 0. The counter increments.
  - After writing address 2**AW-1 the counter wraps to 0 and the state goes to IDLE. BUSY falls on that same edge.
  - The sweep takes exactly 2**AW cycles (1024 at the default).
  - CLR during CLEAR, ACCESS or DONE is ignored, not queued.
- RD registers update only on a completed read by their own requester. A write never changes RD.
- RAM_RE = 0 except during a read ACCESS, so the RAM's Q bus floats otherwise. RAM_Q is never sampled outside a read ACCESS.
- REQ and WR are assumed stable from assertion through ACK. Changing them mid-transaction has no effect, because the command is latched in IDLE.

Decomposition:
- Shared package (cpu_mem_pkg):
  - state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, CLEAR = 2'd3
  - MEM_AW = 10, MEM_DW = 8, MEM_WORDS = 1024
  - requester ID constants REQ_A = 1'b0, REQ_B = 1'b1
- One sub-module: rr_pick2, a combinational 2-way round-robin chooser. It takes req[1:0] and last, and returns grant_valid and grant_id.
- The FSM, command registers, clear counter and RD registers stay in ram_port_arbiter.
- The test bench instantiates ram_port_arbiter together with ram_1024_word_b.

Test Plan:
1. A write then read, B idle:
   - Stimulus: A writes 10'h3FF <= 8'hA5, then A reads 10'h3FF.
   - Required: each A_ACK arrives exactly 2 cycles after REQ is sampled; A_RD = 8'hA5; B_ACK is never asserted.
2. Simultaneous requests after reset:
   - Stimulus: A reads 10'h010 and B reads 10'h020 (preloaded 8'h11 and 8'h22), both REQ high continuously.
   - Required: grants alternate A, B, A, B; A_RD = 8'h11; B_RD = 8'h22; ACKs never overlap.
3. Clear sweep:
   - Stimulus: preload 10'h000 = 8'h5A and 10'h3FF = 8'hC3, pulse CLR.
   - Required: BUSY is high for exactly 1024 cycles; afterwards reads of 10'h000 and 10'h3FF return FILL (8'h00).
4. Clear priority:
   - Stimulus: raise CLR and B_REQ in the same IDLE cycle.
   - Required: CLEAR runs first; B_ACK is asserted 2 cycles after BUSY falls; B's access sees the cleared memory.
5. Reset mid-operation:
   - Stimulus: drive RST_N low during a write ACCESS (addr 10'h055, data 8'hFF; word previously 8'h00).
   - Required: no ACK; the word still reads 8'h00; all outputs are at reset values one cycle later.
6. RD hold:
   - Stimulus: B reads 8'h22, then B writes 8'h77 to another address.
   - Required: B_RD stays 8'h22 through and after the write's ACK.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding, memory geometry and requester ids for the RAM port arbiter.
package cpu_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2, CLEAR = 2'd3} state_e;
  localparam int MEM_AW = 10;
  localparam int MEM_DW = 8;
  localparam int MEM_WORDS = 1024;
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;
endpackage

// File: rtl/ram_1024_word_b.sv
// ram_1024_word_b: behavioural 1024x8 RAM with synchronous write and combinational read that floats when not enabled.
module ram_1024_word_b (
  input  logic       CLK,
  input  logic       WE,
  input  logic       RE,
  input  logic [9:0] RA,
  input  logic [9:0] WA,
  input  logic [7:0] WD,
  output logic [7:0] Q
);
  logic [7:0] mem [1024];
  always_ff @(posedge CLK) if (WE) mem[WA] <= WD;
  assign Q = RE ? mem[RA] : 8'bz;
endmodule

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin chooser; on a tie the requester that was not served last wins.
module rr_pick2
  import cpu_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_id
);
  assign grant_valid = |req;
  assign grant_id = &req ? ~last : (req[1] ? REQ_B : REQ_A);
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one RAM read/write port pair between two requesters, plus a full-memory clear sweep.
module ram_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          A_REQ,
  input  logic          A_WR,
  input  logic [AW-1:0] A_ADDR,
  input  logic [DW-1:0] A_WD,
  output logic          A_ACK,
  output logic [DW-1:0] A_RD,
  input  logic          B_REQ,
  input  logic          B_WR,
  input  logic [AW-1:0] B_ADDR,
  input  logic [DW-1:0] B_WD,
  output logic          B_ACK,
  output logic [DW-1:0] B_RD,
  input  logic          CLR,
  output logic          BUSY,
  output logic          RAM_WE,
  output logic          RAM_RE,
  output logic [AW-1:0] RAM_RA,
  output logic [AW-1:0] RAM_WA,
  output logic [DW-1:0] RAM_WD,
  input  logic [DW-1:0] RAM_Q
);
  state_e        state_q, state_d;
  logic          last_q, last_d, win_q, win_d, wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d, cnt_q, cnt_d;
  logic [DW-1:0] wd_q, wd_d, a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic          grant_valid, grant_id, access, clear, wr_access;
  rr_pick2 u_pick (
    .req        ({B_REQ, A_REQ}),
    .last       (last_q),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      last_q  <= REQ_B;
      win_q   <= REQ_A;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      cnt_q   <= '0;
      a_rd_q  <= '0;
      b_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      cnt_q   <= cnt_d;
      a_rd_q  <= a_rd_d;
      b_rd_q  <= b_rd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    a_rd_d  = a_rd_q;
    b_rd_d  = b_rd_q;
    case (state_q)
      IDLE: begin
        if (CLR) state_d = CLEAR;
        else if (grant_valid) begin
          state_d = ACCESS;
          last_d  = grant_id;
          win_d   = grant_id;
          wr_d    = grant_id ? B_WR : A_WR;
          addr_d  = grant_id ? B_ADDR : A_ADDR;
          wd_d    = grant_id ? B_WD : A_WD;
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (!wr_q && win_q == REQ_B) b_rd_d = RAM_Q;
        if (!wr_q && win_q == REQ_A) a_rd_d = RAM_Q;
      end
      DONE: state_d = IDLE;
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign access    = state_q == ACCESS;
  assign clear     = state_q == CLEAR;
  assign wr_access = access & wr_q;
  // Gating with RST_N keeps a write from committing on an edge where reset is held.
  assign RAM_WE = RST_N & (clear | wr_access);
  assign RAM_RE = access & ~wr_q;
  assign RAM_RA = RAM_RE ? addr_q : '0;
  assign RAM_WA = clear ? cnt_q : (wr_access ? addr_q : '0);
  assign RAM_WD = clear ? FILL : (wr_access ? wd_q : '0);
  assign BUSY   = clear;
  assign A_ACK  = state_q == DONE && win_q == REQ_A;
  assign B_ACK  = state_q == DONE && win_q == REQ_B;
  assign A_RD   = a_rd_q;
  assign B_RD   = b_rd_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scenario tasks plus randomized traffic checked against a word-array memory model and round-robin rule.
module tb_ram_port_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       a_req = 0, a_wr = 0, b_req = 0, b_wr = 0, clr = 0;
  logic [9:0] a_addr = 0, b_addr = 0;
  logic [7:0] a_wd = 0, b_wd = 0;
  logic       a_ack, b_ack, busy, ram_we, ram_re;
  logic [7:0] a_rd, b_rd, ram_wd, ram_q;
  logic [9:0] ram_ra, ram_wa;
  int         checks = 0, passed = 0;
  logic [7:0] mem_m [1024];
  logic [7:0] a_rd_m = 0, b_rd_m = 0;
  logic       last_m = 1'b1;

  always #5 clk = ~clk;

  ram_port_arbiter dut (
    .CLK(clk), .RST_N(rst_n),
    .A_REQ(a_req), .A_WR(a_wr), .A_ADDR(a_addr), .A_WD(a_wd), .A_ACK(a_ack), .A_RD(a_rd),
    .B_REQ(b_req), .B_WR(b_wr), .B_ADDR(b_addr), .B_WD(b_wd), .B_ACK(b_ack), .B_RD(b_rd),
    .CLR(clr), .BUSY(busy),
    .RAM_WE(ram_we), .RAM_RE(ram_re), .RAM_RA(ram_ra), .RAM_WA(ram_wa), .RAM_WD(ram_wd), .RAM_Q(ram_q)
  );
  ram_1024_word_b u_ram (
    .CLK(clk), .WE(ram_we), .RE(ram_re), .RA(ram_ra), .WA(ram_wa), .WD(ram_wd), .Q(ram_q)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; a_req = 0; b_req = 0; clr = 0;
    tick; tick;
    rst_n = 1;
    last_m = 1'b1; a_rd_m = 0; b_rd_m = 0;
  endtask

  task automatic check_idle_outputs(input string nm);
    checks++;
    if ({a_ack, b_ack, busy, ram_we, ram_re, ram_ra, ram_wa, ram_wd, a_rd, b_rd} !== '0)
      $display("FAIL %s: outputs ack=%b%b busy=%b we=%b re=%b ra=%h wa=%h wd=%h ard=%h brd=%h, required all zero",
               nm, a_ack, b_ack, busy, ram_we, ram_re, ram_ra, ram_wa, ram_wd, a_rd, b_rd);
    else passed++;
  endtask

  // Drives the requested accesses; ua/ub say who requests, hold keeps both REQs high until n_acks served.
  task automatic run(input logic ua, ub, wra, wrb, input logic [9:0] aa, ab, input logic [7:0] da, db,
                     input int n_acks, input logic hold, input string nm);
    int cyc = 0, got = 0, next_exp = 2;
    logic pa = ua, pb = ub, who, exp_who;
    a_req = ua; a_wr = wra; a_addr = aa; a_wd = da;
    b_req = ub; b_wr = wrb; b_addr = ab; b_wd = db;
    while (got < n_acks && cyc < 40) begin
      tick;
      cyc++;
      checks++;
      if (a_ack && b_ack) $display("FAIL %s overlap: both ACKs high at cycle %0d, required at most one", nm, cyc);
      else passed++;
      if (a_ack || b_ack) begin
        who = b_ack;
        exp_who = (pa && pb) ? ~last_m : pb;
        checks++;
        if (who !== exp_who || !(pa || pb)) $display("FAIL %s grant: got %s, required %s", nm, who ? "B" : "A", exp_who ? "B" : "A");
        else passed++;
        checks++;
        if (cyc != next_exp) $display("FAIL %s latency: ack at cycle %0d, required %0d", nm, cyc, next_exp);
        else passed++;
        next_exp += 3;
        last_m = who;
        if (who ? wrb : wra) mem_m[who ? ab : aa] = who ? db : da;
        else if (who) b_rd_m = mem_m[ab];
        else a_rd_m = mem_m[aa];
        if (!hold && who) begin b_req = 0; pb = 0; end
        if (!hold && !who) begin a_req = 0; pa = 0; end
        got++;
      end
      checks++;
      if (a_rd !== a_rd_m || b_rd !== b_rd_m) $display("FAIL %s rd: A_RD=%h B_RD=%h, required %h %h", nm, a_rd, b_rd, a_rd_m, b_rd_m);
      else passed++;
    end
    checks++;
    if (got != n_acks) $display("FAIL %s acks: got %0d, required %0d", nm, got, n_acks);
    else passed++;
    a_req = 0; b_req = 0;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    check_idle_outputs("reset");
  endtask

  task automatic test_write_read;
    run(1, 0, 1, 0, 10'h3FF, 0, 8'hA5, 0, 1, 0, "a_write");
    run(1, 0, 0, 0, 10'h3FF, 0, 0, 0, 1, 0, "a_read");
    checks++;
    if (a_rd !== 8'hA5) $display("FAIL a_read value: A_RD=%h, required a5", a_rd);
    else passed++;
  endtask

  task automatic test_simultaneous;
    run(1, 0, 1, 0, 10'h010, 0, 8'h11, 0, 1, 0, "preload_a");
    run(0, 1, 0, 1, 0, 10'h020, 0, 8'h22, 1, 0, "preload_b");
    do_reset;
    run(1, 1, 0, 0, 10'h010, 10'h020, 0, 0, 4, 1, "simul");
    checks++;
    if (a_rd !== 8'h11 || b_rd !== 8'h22) $display("FAIL simul values: A_RD=%h B_RD=%h, required 11 22", a_rd, b_rd);
    else passed++;
  endtask

  task automatic wait_busy_low(input string nm);
    int n = 0;
    while (busy && n < 1100) begin n++; tick; end
    checks++;
    if (n != 1024) $display("FAIL %s busy length: %0d cycles, required 1024", nm, n);
    else passed++;
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
  endtask

  task automatic test_clear;
    run(1, 0, 1, 0, 10'h000, 0, 8'h5A, 0, 1, 0, "preload_lo");
    run(0, 1, 0, 1, 0, 10'h3FF, 0, 8'hC3, 1, 0, "preload_hi");
    clr = 1;
    tick;
    clr = 0;
    wait_busy_low("clear");
    run(1, 0, 0, 0, 10'h000, 0, 0, 0, 1, 0, "clear_rd_lo");
    run(0, 1, 0, 0, 0, 10'h3FF, 0, 0, 1, 0, "clear_rd_hi");
    checks++;
    if (a_rd !== 8'h00 || b_rd !== 8'h00) $display("FAIL clear values: A_RD=%h B_RD=%h, required 00 00", a_rd, b_rd);
    else passed++;
  endtask

  task automatic test_clear_priority;
    int n = 0;
    run(0, 1, 0, 1, 0, 10'h123, 0, 8'h9C, 1, 0, "prio_preload");
    run(0, 1, 0, 0, 0, 10'h123, 0, 0, 1, 0, "prio_preread");
    clr = 1; b_req = 1; b_wr = 0; b_addr = 10'h123;
    tick;
    clr = 0;
    checks++;
    if (busy !== 1'b1 || b_ack !== 1'b0) $display("FAIL prio start: BUSY=%b B_ACK=%b, required 1 0", busy, b_ack);
    else passed++;
    wait_busy_low("prio");
    while (!b_ack && n < 10) begin tick; n++; end
    checks++;
    if (n != 2) $display("FAIL prio ack delay: %0d cycles after BUSY fell, required 2", n);
    else passed++;
    checks++;
    if (b_rd !== 8'h00) $display("FAIL prio value: B_RD=%h, required 00", b_rd);
    else passed++;
    b_rd_m = 8'h00; last_m = 1'b1;
    b_req = 0;
    tick;
  endtask

  task automatic test_reset_mid;
    run(1, 0, 1, 0, 10'h055, 0, 8'h00, 0, 1, 0, "mid_preload");
    a_req = 1; a_wr = 1; a_addr = 10'h055; a_wd = 8'hFF;
    tick;
    checks++;
    if (ram_we !== 1'b1) $display("FAIL mid access: RAM_WE=%b, required 1", ram_we);
    else passed++;
    rst_n = 0; a_req = 0;
    tick;
    check_idle_outputs("mid_reset");
    rst_n = 1; last_m = 1'b1; a_rd_m = 0; b_rd_m = 0;
    tick;
    checks++;
    if (a_ack !== 1'b0) $display("FAIL mid ack: A_ACK=%b, required 0", a_ack);
    else passed++;
    run(1, 0, 0, 0, 10'h055, 0, 0, 0, 1, 0, "mid_read");
    checks++;
    if (a_rd !== 8'h00) $display("FAIL mid value: A_RD=%h, required 00", a_rd);
    else passed++;
  endtask

  task automatic test_rd_hold;
    run(0, 1, 0, 1, 0, 10'h200, 0, 8'h22, 1, 0, "hold_preload");
    run(0, 1, 0, 0, 0, 10'h200, 0, 0, 1, 0, "hold_read");
    run(0, 1, 0, 1, 0, 10'h201, 0, 8'h77, 1, 0, "hold_write");
    tick;
    checks++;
    if (b_rd !== 8'h22) $display("FAIL hold value: B_RD=%h, required 22", b_rd);
    else passed++;
  endtask

  task automatic test_random;
    logic ua, ub;
    for (int i = 0; i < 40; i++) begin
      ua = 1'($urandom_range(0, 1));
      ub = ua ? 1'($urandom_range(0, 1)) : 1'b1;
      run(ua, ub, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          10'($urandom_range(0, 7)), 10'($urandom_range(0, 7)),
          8'($urandom), 8'($urandom), int'(ua) + int'(ub), 0, "random");
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_simultaneous;
    for (int i = 0; i < 8; i++) run(1, 0, 1, 0, 10'(i), 0, 8'(i * 37 + 1), 0, 1, 0, "rand_init");
    test_random;
    test_clear;
    test_clear_priority;
    test_reset_mid;
    test_rd_hold;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
